// File: rtl/intc_ctrl_pkg.sv
// rtl/intc_ctrl_pkg.sv - shared register map, FSM encoding and constants for intc_ctrl
package intc_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [3:0] INTC_CTRL    = 4'h0;
    localparam logic [3:0] INTC_ENABLE  = 4'h4;
    localparam logic [3:0] INTC_PENDING = 4'h8;
    localparam logic [3:0] INTC_STATUS  = 4'hC;

    localparam int STATUS_REQ_BIT = 8;
    localparam int STATUS_SRV_BIT = 9;

    typedef enum logic [1:0] {
        INTC_IDLE    = 2'd0,
        INTC_REQ     = 2'd1,
        INTC_SERVICE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - fixed-priority encoder, lowest set index wins
module intc_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic [N_SRC-1:0] eligible_i,
    output logic             any_valid_o,
    output logic [ID_W-1:0]  win_id_o
);

    // Scan from the top so the last hit, the lowest index, is what remains.
    always_comb begin
        any_valid_o = 1'b0;
        win_id_o    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                any_valid_o = 1'b1;
                win_id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_ctrl.sv
// rtl/intc_ctrl.sv - interrupt controller: pending latch, masking, priority and req/ack/done handshake
// Optional build macro INTC_EDGE_DETECT_EN: treat irq_src_i as levels and latch rising edges only.
module intc_ctrl
    import intc_ctrl_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             intc_we,
    input  logic [31:0]      intc_adr,
    input  logic [31:0]      intc_wdata,
    output logic [31:0]      intc_rdata,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic             int_req_o,
    output logic [ID_W-1:0]  int_id_o,
    input  logic             int_ack_i,
    input  logic             int_done_i
);

    logic             ctrl_q, ctrl_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    intc_state_e      state_q, state_d;
    logic             req_q, req_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] id_onehot;
    logic [N_SRC-1:0] w1c_vec;
    logic [N_SRC-1:0] ack_clr;
    logic             any_valid;
    logic [ID_W-1:0]  win_id;
    logic             id_eligible;
    logic             ack_take;
    logic             wr_ctrl, wr_enable, wr_pending;
    logic [3:0]       adr_lo;
    logic             unused_bits;

`ifdef INTC_EDGE_DETECT_EN
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] prev_q;

    // Registering the input first keeps the edge detector off the raw pins; costs one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            prev_q <= '0;
        end else begin
            src_q  <= irq_src_i;
            prev_q <= src_q;
        end
    end

    assign set_vec = src_q & ~prev_q;
`else
    assign set_vec = irq_src_i;
`endif

    assign adr_lo      = intc_adr[3:0];
    assign wr_ctrl     = intc_we && (adr_lo == INTC_CTRL);
    assign wr_enable   = intc_we && (adr_lo == INTC_ENABLE);
    assign wr_pending  = intc_we && (adr_lo == INTC_PENDING);
    assign unused_bits = ^{intc_adr[31:4], intc_wdata[31:N_SRC]};

    assign eligible = pending_q & enable_q & {N_SRC{ctrl_q}};

    intc_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .eligible_i  (eligible),
        .any_valid_o (any_valid),
        .win_id_o    (win_id)
    );

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (id_q == ID_W'(i));
        end
    end

    assign id_eligible = |(eligible & id_onehot);
    assign ack_take    = (state_q == INTC_REQ) && int_ack_i;

    // New arrivals are OR-ed in last so they beat both W1C and the ack clear.
    always_comb begin
        ctrl_d    = ctrl_q;
        enable_d  = enable_q;
        w1c_vec   = wr_pending ? intc_wdata[N_SRC-1:0] : '0;
        ack_clr   = ack_take ? id_onehot : '0;
        if (wr_ctrl) begin
            ctrl_d = intc_wdata[0];
        end
        if (wr_enable) begin
            enable_d = intc_wdata[N_SRC-1:0];
        end
        pending_d = (pending_q & ~w1c_vec & ~ack_clr) | set_vec;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        unique case (state_q)
            INTC_IDLE: begin
                if (any_valid) begin
                    state_d = INTC_REQ;
                    req_d   = TRUE;
                    id_d    = win_id;
                end
            end
            INTC_REQ: begin
                if (int_ack_i) begin
                    state_d = INTC_SERVICE;
                    req_d   = FALSE;
                end else if (!id_eligible) begin
                    state_d = INTC_IDLE;
                    req_d   = FALSE;
                end
            end
            INTC_SERVICE: begin
                if (int_done_i) begin
                    state_d = INTC_IDLE;
                end
            end
            default: begin
                state_d = INTC_IDLE;
                req_d   = FALSE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= 1'b0;
            enable_q  <= '0;
            pending_q <= '0;
            state_q   <= INTC_IDLE;
            req_q     <= 1'b0;
            id_q      <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            req_q     <= req_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        intc_rdata = '0;
        case (adr_lo)
            INTC_CTRL:    intc_rdata[0]         = ctrl_q;
            INTC_ENABLE:  intc_rdata[N_SRC-1:0] = enable_q;
            INTC_PENDING: intc_rdata[N_SRC-1:0] = pending_q;
            INTC_STATUS: begin
                intc_rdata[ID_W-1:0]      = id_q;
                intc_rdata[STATUS_REQ_BIT] = req_q;
                intc_rdata[STATUS_SRV_BIT] = (state_q == INTC_SERVICE);
            end
            default:      intc_rdata = '0;
        endcase
    end

    assign int_req_o = req_q;
    assign int_id_o  = id_q;

endmodule
